fir_sequencer: RTL and testbench
================================

# fir_sequencer

Sequencing controller for the 8-tap FIR datapath: coefficient ROM, sample delay-line RAM and MAC. It accepts one input sample per handshake and writes it into a circular delay line. It then walks all taps, driving ROM/RAM addresses and enables, and frames each accumulation with `mac_init`/`mac_en`. It pulses `valid_out` when the MAC holds a finished output, and supports a delay-line clear that writes zeros through the RAM.

## Interface
- `TAPS`, 8, number of taps; power of two, ≥ 2.
- `ADDR_W`, $clog2(TAPS), ROM/RAM address width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `valid_in`  in  1  new sample present on the datapath input this cycle.
- `clear`  in  1  request to zero the whole delay line.
- `ready`  out  1  high only in IDLE; a sample or clear is accepted on a clock edge where `ready` is high and `valid_in` or `clear` is high.
- `rom_address`  out  ADDR_W  coefficient index.
- `ram_address`  out  ADDR_W  delay-line address.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `zero_sel`  out  1  selects 0 as RAM write data (clear).
- `mac_init`  out  1  MAC loads the product instead of accumulating.
- `mac_en`  out  1  MAC update strobe.
- `valid_out`  out  1  one-cycle pulse: MAC output is final.

## Operation
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Internal registers:
  - `wr_ptr` (ADDR_W): next write slot.
  - `tap` (ADDR_W): tap counter.
  - `rd_d`: 1-cycle delay of the read strobe, which drives `mac_en`.
- States and transitions:
  - IDLE → CLEAR if `clear`; `clear` has priority over `valid_in`.
  - IDLE → WRITE if `valid_in` and not `clear`.
  - WRITE → READ after 1 cycle.
  - READ → DRAIN after TAPS cycles.
  - DRAIN → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
  - CLEAR → IDLE after TAPS cycles.
- WRITE: `ram_en`=`ram_we`=1, `ram_address`=`wr_ptr`.
- READ, tap i = 0..TAPS-1:
  - `ram_en`=1, `ram_we`=0.
  - `ram_address`=(`wr_ptr` − i) mod TAPS, computed as natural ADDR_W wrap; tap 0 is the newest sample.
  - `rom_address`=i.
- MAC framing:
  - `mac_en` = `rd_d`, because the memories have 1-cycle synchronous read latency.
  - `mac_init` is high only together with the first `mac_en` of a sample.
- DRAIN: last `mac_en`. DONE: `valid_out`=1. `wr_ptr` increments (mod TAPS) on the DONE→IDLE edge.
- CLEAR:
  - `ram_en`=`ram_we`=`zero_sel`=1; `ram_address` = 0..TAPS-1.
  - `wr_ptr` is reset to 0 on exit.
  - No `mac_en` and no `valid_out`.
- `valid_in` and `clear` are ignored outside IDLE; no queuing.
- Reset (synchronous, any state):
  - Next state IDLE; `wr_ptr`=`tap`=`rd_d`=0.
  - An in-flight sample is abandoned: no `valid_out`, no further `mac_en`.
  - RAM contents are not cleared by reset.

## Timing
- Reset values, in the cycle after a reset edge:
  - `ready`=1.
  - `rom_address`=`ram_address`=0.
  - `ram_en`=`ram_we`=`zero_sel`=`mac_init`=`mac_en`=`valid_out`=0.
- Cycle-level sequence for a sample accepted at edge E0 (cycle c0 = IDLE):
  - c1 WRITE.
  - c2..c(TAPS+1) READ.
  - c3..c(TAPS+2) `mac_en`; `mac_init` at c3.
  - c(TAPS+3) DONE with `valid_out`.
  - c(TAPS+4) IDLE with `ready`=1.
- For TAPS=8: `valid_out` at c11; the next sample can be accepted at the edge ending c12; the sample period is 12 cycles.
- Clear accepted at E0: zero writes in c1..cTAPS, `ready` high again at c(TAPS+1).

## Structure
- Package `fir_pkg` holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE, CLEAR);
  - the default TAPS constant;
  - the ADDR_W derivation.
- Single module. The FSM, tap counter, `wr_ptr` and `rd_d` pipeline flop fit comfortably in one module; no sub-module.

## Test plan
- Reset, then idle 5 cycles → `ready`=1 and all other outputs 0 throughout.
- One sample, TAPS=8, `wr_ptr`=0:
  - RAM write at address 0 in c1.
  - Reads at 0,7,6,5,4,3,2,1 with ROM addresses 0..7 in c2..c9.
  - `mac_init` in c3 only; `mac_en` in c3..c10; `valid_out` in c11 only.
- 9 back-to-back samples, `valid_in` held high → accepts exactly every 12 cycles. The 9th sample writes address 0, confirming `wr_ptr` wrap; tap 1 of the 9th sample reads address 7.
- `clear` and `valid_in` both high in IDLE → CLEAR runs, with `zero_sel`=1 writes at addresses 0..7. No WRITE occurs and no `mac_en`; `wr_ptr`=0 afterwards.
- `valid_in` pulsed during READ → ignored; no extra WRITE and the running sequence is unchanged.
- `reset` asserted in c5 of a sample → IDLE outputs from c6, no `valid_out`, `wr_ptr`=0. The next sample writes address 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and sizing for the 8-tap FIR sequencer and its datapath.
package fir_pkg;

  localparam int TAPS_DEFAULT = 8;

  // Keeps the address at least one bit wide, even at the minimum tap count.
  function automatic int addr_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE,
    CLEAR
  } state_t;

endpackage

// File: rtl/fir_sequencer.sv
// Controller for the FIR datapath: writes each sample into a circular delay line,
// walks the taps against the coefficient ROM and frames the MAC accumulation.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS   = TAPS_DEFAULT,
  parameter int ADDR_W = addr_width(TAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              clear,
  output logic              ready,
  output logic [ADDR_W-1:0] rom_address,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_en,
  output logic              ram_we,
  output logic              zero_sel,
  output logic              mac_init,
  output logic              mac_en,
  output logic              valid_out
);

  localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] TAP_ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] tap;
  logic              rd_d;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      tap    <= '0;
      rd_d   <= 1'b0;
    end else begin
      // Memories answer one cycle after the read, so the MAC strobe trails it.
      rd_d <= (state == READ);
      case (state)
        IDLE: begin
          tap <= '0;
          if (clear)         state <= CLEAR;
          else if (valid_in) state <= WRITE;
        end
        WRITE: begin
          tap   <= '0;
          state <= READ;
        end
        READ: begin
          tap <= tap + 1'b1;
          if (tap == TAP_LAST) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= IDLE;
        end
        CLEAR: begin
          tap <= tap + 1'b1;
          if (tap == TAP_LAST) begin
            wr_ptr <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    rom_address = '0;
    ram_address = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    zero_sel    = 1'b0;
    case (state)
      WRITE: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_address = wr_ptr;
      end
      READ: begin
        ram_en      = 1'b1;
        ram_address = wr_ptr - tap;
        rom_address = tap;
      end
      CLEAR: begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        zero_sel    = 1'b1;
        ram_address = tap;
      end
      default: ;
    endcase
  end

  assign ready     = (state == IDLE);
  assign mac_en    = rd_d;
  // The first MAC strobe lands while the counter already points at tap 1.
  assign mac_init  = rd_d && (state == READ) && (tap == TAP_ONE);
  assign valid_out = (state == DONE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer: per-cycle expected output vectors are queued
// when stimulus is driven and compared on the falling edge.
module tb_fir_sequencer;
  import fir_pkg::*;

  localparam int TAPS   = TAPS_DEFAULT;
  localparam int ADDR_W = addr_width(TAPS);
  localparam int VW     = 7 + 2 * ADDR_W;
  typedef logic [VW-1:0] vec_t;

  logic              clock;
  logic              reset;
  logic              valid_in;
  logic              clear;
  logic              ready;
  logic [ADDR_W-1:0] rom_address;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_en;
  logic              ram_we;
  logic              zero_sel;
  logic              mac_init;
  logic              mac_en;
  logic              valid_out;

  fir_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .valid_in   (valid_in),
    .clear      (clear),
    .ready      (ready),
    .rom_address(rom_address),
    .ram_address(ram_address),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .zero_sel   (zero_sel),
    .mac_init   (mac_init),
    .mac_en     (mac_en),
    .valid_out  (valid_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int                tests    = 0;
  int                failures = 0;
  logic [ADDR_W-1:0] exp_wp   = '0;
  vec_t              exp_q[$];
  string             tag_q[$];

  function automatic vec_t mk(input logic rdy, input logic [ADDR_W-1:0] rom,
                              input logic [ADDR_W-1:0] ram, input logic en, input logic we,
                              input logic zs, input logic mi, input logic me, input logic vo);
    return {rdy, rom, ram, en, we, zs, mi, me, vo};
  endfunction

  // Field order: ready, rom_address, ram_address, ram_en, ram_we, zero_sel, mac_init, mac_en, valid_out
  always @(negedge clock) begin
    vec_t  obs;
    vec_t  exp;
    string tag;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = {ready, rom_address, ram_address, ram_en, ram_we, zero_sel, mac_init, mac_en, valid_out};
      tests++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: outputs got %b, expected %b (rdy,rom,ram,en,we,zs,init,mac,vout)",
                 tag, obs, exp);
      end
    end
  end

  task automatic push(input vec_t v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic push_idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      push(mk(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), $sformatf("%s_idle%0d", tag, i));
  endtask

  // First n cycles of the sample timeline c0..c(TAPS+3) for write pointer p.
  task automatic push_sample(input logic [ADDR_W-1:0] p, input int n, input string tag);
    vec_t v[$];
    logic [ADDR_W-1:0] ti;
    v.push_back(mk(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, '0, p, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < TAPS; i++) begin
      ti = ADDR_W'(i);
      v.push_back(mk(1'b0, ti, p - ti, 1'b1, 1'b0, 1'b0, i == 1, i >= 1, 1'b0));
    end
    v.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int c = 0; c < n && c < v.size(); c++) push(v[c], $sformatf("%s_c%0d", tag, c));
  endtask

  task automatic push_clear(input string tag);
    push(mk(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), $sformatf("%s_c0", tag));
    for (int i = 0; i < TAPS; i++)
      push(mk(1'b0, '0, ADDR_W'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
           $sformatf("%s_c%0d", tag, i + 1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      failures++;
      $display("FAIL %s_timeout: %0d expectations left, required 0", tag, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic test_reset();
    @(posedge clock);
    #1;
    tests++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, required 1", ready);
    end
    push_idle(5, "reset");
    drain("reset");
  endtask

  task automatic test_single_sample(input string tag);
    @(posedge clock);
    #1;
    push_sample(exp_wp, TAPS + 4, tag);
    push_idle(2, tag);
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    exp_wp++;
    drain(tag);
  endtask

  task automatic test_clear_priority();
    @(posedge clock);
    #1;
    push_clear("clear");
    push_idle(2, "clear_end");
    clear    = 1'b1;
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    exp_wp   = '0;
    drain("clear");
  endtask

  task automatic test_back_to_back();
    @(posedge clock);
    #1;
    for (int k = 0; k < 9; k++) begin
      push_sample(exp_wp, TAPS + 4, $sformatf("b2b%0d", k));
      exp_wp++;
    end
    valid_in = 1'b1;
    repeat (8 * (TAPS + 4) + 1) @(posedge clock);
    #1;
    valid_in = 1'b0;
    push_idle(3, "b2b_end");
    drain("b2b");
  endtask

  task automatic test_ignore_inputs();
    @(posedge clock);
    #1;
    push_sample(exp_wp, TAPS + 4, "ignore");
    push_idle(3, "ignore_end");
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    clear    = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    exp_wp++;
    drain("ignore");
  endtask

  task automatic test_reset_mid_sample();
    @(posedge clock);
    #1;
    push_sample(exp_wp, 6, "rstmid");
    push_idle(5, "rstmid_after");
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    exp_wp = '0;
    drain("rstmid");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_single_sample("single");
    test_clear_priority();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid_sample();
    test_single_sample("post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
